// File: rtl/coarse_read_counter_if.sv
`default_nettype none
// ============================================================================
// Interface : coarse_read_counter_if
// Brief     : Bundle of the coarse-loop handshake signals. The master side
//             drives the analog status and fine pulses and reads back the
//             counter. The slave side is the read counter itself.
// Revision  : 1.0  initial release
// ============================================================================
interface coarse_read_counter_if;
   logic        tlc1;      // coarse Schmitt error, asynchronous
   logic        adhi;      // ambiguity detect, asynchronous
   logic        dir;       // slew direction, 1 = up
   logic        fine_up;   // +1 LSB pulse
   logic        fine_dn;   // -1 LSB pulse
   logic [15:0] angle;     // read counter
   logic [11:0] dc_n;      // active-low coarse switch selects
   logic        step_up;   // counter incremented last edge
   logic        step_dn;   // counter decremented last edge
   logic        step_crs;  // last step was a coarse step
   logic        slewing;   // coarse slew in progress

   modport master (
      output tlc1, adhi, dir, fine_up, fine_dn,
      input  angle, dc_n, step_up, step_dn, step_crs, slewing
   );

   modport slave (
      input  tlc1, adhi, dir, fine_up, fine_dn,
      output angle, dc_n, step_up, step_dn, step_crs, slewing
   );
endinterface
`default_nettype wire

// File: rtl/coarse_read_counter.sv
`default_nettype none
// ============================================================================
// Module   : coarse_read_counter
// Brief    : Digital side of the CDU coarse loop. Owns the 16-bit read
//            counter (2^16 = 360 deg) and follows fine up/down pulses. While
//            the coarse error persists it slews the counter in 2^9-LSB steps
//            and waits for the coarse ladder to settle between steps. It
//            also decodes the counter into the active-low switch selects.
// Revision : 1.0  initial release
// ============================================================================
module coarse_read_counter #(
   parameter int DEBOUNCE = 4,   // consecutive synced error cycles before slewing
   parameter int SETTLE   = 8    // wait cycles after each coarse step
) (
   input  wire logic            clk,
   input  wire logic            rst,
   coarse_read_counter_if.slave bus
);

   localparam int QW = $clog2(DEBOUNCE + 2);
   localparam int TW = $clog2(SETTLE + 2);
   localparam logic [QW-1:0] c_debounce = QW'(DEBOUNCE);
   localparam logic [TW-1:0] c_settle   = TW'(SETTLE);
   localparam logic [15:0]   c_coarse   = 16'h0200;
   localparam logic [11:0]   c_dc_rst   = 12'hEBE;   // decode of angle 0

   typedef enum logic [1:0] {
      ST_TRACK  = 2'd0,
      ST_QUAL   = 2'd1,
      ST_SLEW   = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   // Synchronisers
   logic r_tlc1_m, r_tlc1_s;
   logic r_adhi_m, r_adhi_s;

   // Core state
   state_t          r_state, w_state_nx;
   logic [QW-1:0]   r_qcnt,  w_qcnt_nx;
   logic [TW-1:0]   r_tmr,   w_tmr_nx;
   logic [15:0]     r_angle, w_angle_nx;
   logic            w_inc, w_dec, w_crs;

   // Outputs
   logic            r_step_up, r_step_dn, r_step_crs;
   logic [11:0]     r_dc_n, w_dc_n;
   logic [7:0]      w_oct_low;

   logic            w_fine_inc, w_fine_dec;
   logic [QW-1:0]   w_qcnt_inc;

   // Opposing fine pulses in the same cycle cancel.
   assign w_fine_inc = bus.fine_up & ~bus.fine_dn;
   assign w_fine_dec = bus.fine_dn & ~bus.fine_up;
   assign w_qcnt_inc = r_qcnt + 1'b1;

   // Two-flop synchronisers for the asynchronous analog status lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tlc1_m <= 1'b0;
         r_tlc1_s <= 1'b0;
         r_adhi_m <= 1'b0;
         r_adhi_s <= 1'b0;
      end else begin
         r_tlc1_m <= bus.tlc1;
         r_tlc1_s <= r_tlc1_m;
         r_adhi_m <= bus.adhi;
         r_adhi_s <= r_adhi_m;
      end
   end

   // Next-state, counter update and step qualifiers.
   always_comb begin
      w_state_nx = r_state;
      w_qcnt_nx  = r_qcnt;
      w_tmr_nx   = r_tmr;
      w_angle_nx = r_angle;
      w_inc      = 1'b0;
      w_dec      = 1'b0;
      w_crs      = 1'b0;

      // Fine tracking continues while the coarse error is being qualified.
      if ((r_state == ST_TRACK) || (r_state == ST_QUAL)) begin
         if (w_fine_inc) begin
            w_angle_nx = r_angle + 16'd1;
            w_inc      = 1'b1;
         end else if (w_fine_dec) begin
            w_angle_nx = r_angle - 16'd1;
            w_dec      = 1'b1;
         end
      end

      case (r_state)
         ST_TRACK: begin
            if (r_tlc1_s) begin
               w_qcnt_nx  = QW'(1);
               w_state_nx = (DEBOUNCE <= 1) ? ST_SLEW : ST_QUAL;
            end
         end
         ST_QUAL: begin
            if (!r_tlc1_s) begin
               w_qcnt_nx  = '0;
               w_state_nx = ST_TRACK;
            end else if (w_qcnt_inc >= c_debounce) begin
               w_qcnt_nx  = '0;
               w_state_nx = ST_SLEW;
            end else begin
               w_qcnt_nx  = w_qcnt_inc;
            end
         end
         ST_SLEW: begin
            // Ambiguity detect overrides the phase detector and forces up.
            if (r_adhi_s || bus.dir) begin
               w_angle_nx = r_angle + c_coarse;
               w_inc      = 1'b1;
            end else begin
               w_angle_nx = r_angle - c_coarse;
               w_dec      = 1'b1;
            end
            w_crs      = 1'b1;
            w_qcnt_nx  = '0;
            w_tmr_nx   = c_settle;
            w_state_nx = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_tmr <= TW'(1)) begin
               w_tmr_nx   = '0;
               w_state_nx = r_tlc1_s ? ST_SLEW : ST_TRACK;
            end else begin
               w_tmr_nx   = r_tmr - 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_TRACK;
         end
      endcase
   end

   // State, counters and read counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_TRACK;
         r_qcnt  <= '0;
         r_tmr   <= '0;
         r_angle <= 16'h0000;
      end else begin
         r_state <= w_state_nx;
         r_qcnt  <= w_qcnt_nx;
         r_tmr   <= w_tmr_nx;
         r_angle <= w_angle_nx;
      end
   end

   // Octant decode: each octant pulls exactly two of DC1..DC8 low (bit i-1 = DCi).
   always_comb begin
      w_oct_low = 8'h00;
      case (r_angle[15:13])
         3'd0:    w_oct_low = 8'h41;   // DC1, DC7
         3'd1:    w_oct_low = 8'h82;   // DC2, DC8
         3'd2:    w_oct_low = 8'h88;   // DC4, DC8
         3'd3:    w_oct_low = 8'h44;   // DC3, DC7
         3'd4:    w_oct_low = 8'h14;   // DC3, DC5
         3'd5:    w_oct_low = 8'h28;   // DC4, DC6
         3'd6:    w_oct_low = 8'h22;   // DC2, DC6
         default: w_oct_low = 8'h11;   // DC1, DC5
      endcase
      w_dc_n = ~{r_angle[9], r_angle[10], r_angle[11], ~r_angle[12], w_oct_low};
   end

   // Registered step pulses and switch selects.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step_up  <= 1'b0;
         r_step_dn  <= 1'b0;
         r_step_crs <= 1'b0;
         r_dc_n     <= c_dc_rst;
      end else begin
         r_step_up  <= w_inc;
         r_step_dn  <= w_dec;
         r_step_crs <= w_crs;
         r_dc_n     <= w_dc_n;
      end
   end

   assign bus.angle    = r_angle;
   assign bus.dc_n     = r_dc_n;
   assign bus.step_up  = r_step_up;
   assign bus.step_dn  = r_step_dn;
   assign bus.step_crs = r_step_crs;
   assign bus.slewing  = (r_state == ST_SLEW) || (r_state == ST_SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_coarse_read_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_coarse_read_counter
// Brief    : Self-checking bench for coarse_read_counter. Fine-pulse table,
//            coarse slew sequences, debounce boundary, wrap and reset abort.
//            Every step pulse is matched against a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_coarse_read_counter;

   localparam int DEBOUNCE = 4;
   localparam int SETTLE   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] exp_angle = 16'h0000;

   always #5 clk = ~clk;

   // Free-running cycle count used to measure step spacing.
   always @(posedge clk) cyc <= cyc + 1;

   coarse_read_counter_if bus_if();

   coarse_read_counter #(
      .DEBOUNCE (DEBOUNCE),
      .SETTLE   (SETTLE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct packed {
      logic [15:0] angle;
      logic        up;
      logic        crs;
   } step_t;

   typedef struct {
      logic        up;
      logic        dn;
      logic [15:0] angle;
      logic        su;
      logic        sd;
   } vec_t;

   step_t sb_q[$];
   vec_t  vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Switch-select model written directly from the octant table.
   function automatic logic [11:0] dc_model(input logic [15:0] a);
      int lows [8][2] = '{'{1,7}, '{2,8}, '{4,8}, '{3,7}, '{3,5}, '{4,6}, '{2,6}, '{1,5}};
      logic [11:0] m = 12'hFFF;
      int k = int'(a[15:13]);
      m[lows[k][0]-1] = 1'b0;
      m[lows[k][1]-1] = 1'b0;
      if (!a[12]) m[8]  = 1'b0;
      if (a[11])  m[9]  = 1'b0;
      if (a[10])  m[10] = 1'b0;
      if (a[9])   m[11] = 1'b0;
      return m;
   endfunction

   // Scoreboard monitor: every step pulse must match the oldest expectation.
   always @(negedge clk) begin
      step_t e;
      if (!rst && (bus_if.step_up || bus_if.step_dn)) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step: got angle %0h up %0b dn %0b crs %0b expected no step",
                     bus_if.angle, bus_if.step_up, bus_if.step_dn, bus_if.step_crs);
         end else begin
            e = sb_q.pop_front();
            check("step_record", {bus_if.angle, bus_if.step_up, bus_if.step_dn, bus_if.step_crs},
                  {e.angle, e.up, ~e.up, e.crs});
         end
      end
      if (bus_if.step_up && bus_if.step_dn) begin
         total++;
         bad++;
         $display("FAIL step_exclusive: got up=1 dn=1 expected at most one");
      end
   end

   // One fine pulse; returns at the negedge where its effect is visible.
   task automatic apply_fine(input logic up, input logic dn);
      logic [15:0] nx;
      nx = exp_angle;
      if (up && !dn)      nx = exp_angle + 16'd1;
      else if (dn && !up) nx = exp_angle - 16'd1;
      @(negedge clk);
      bus_if.fine_up = up;
      bus_if.fine_dn = dn;
      if (nx != exp_angle) sb_q.push_back('{angle: nx, up: (up && !dn), crs: 1'b0});
      @(negedge clk);
      bus_if.fine_up = 1'b0;
      bus_if.fine_dn = 1'b0;
      exp_angle = nx;
   endtask

   // Hold the coarse error until n coarse steps have been seen, then release.
   task automatic slew_n(input int n, input logic d, input logic a);
      logic [15:0] m;
      logic        seen;
      int          last;
      m = exp_angle;
      for (int i = 0; i < n; i++) begin
         m = (d || a) ? m + 16'h0200 : m - 16'h0200;
         sb_q.push_back('{angle: m, up: (d || a), crs: 1'b1});
      end
      @(negedge clk);
      bus_if.dir  = d;
      bus_if.adhi = a;
      bus_if.tlc1 = 1'b1;
      last = 0;
      for (int i = 0; i < n; i++) begin
         seen = 1'b0;
         for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = bus_if.step_up || bus_if.step_dn;
         end
         if (!seen) begin
            total++;
            bad++;
            $display("FAIL slew_timeout: got %0d steps expected %0d", i, n);
            i = n;
         end else begin
            if (i == 0) check("slewing_in_settle", bus_if.slewing, 1'b1);
            else        check("step_spacing", cyc - last, SETTLE + 1);
            last = cyc;
         end
      end
      bus_if.tlc1 = 1'b0;
      repeat (20) @(negedge clk);
      exp_angle = m;
      sb_q.delete();
      check("slew_end_slewing", bus_if.slewing, 1'b0);
      check("slew_end_angle", bus_if.angle, m);
      check("slew_end_dc_n", bus_if.dc_n, dc_model(m));
   endtask

   initial begin
      logic flag;
      bus_if.tlc1    = 1'b0;
      bus_if.adhi    = 1'b0;
      bus_if.dir     = 1'b0;
      bus_if.fine_up = 1'b0;
      bus_if.fine_dn = 1'b0;

      //            up    dn    angle      su    sd
      vecs[0] = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};

      // Reset held three cycles.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_angle", bus_if.angle, 16'h0000);
      check("rst_dc_n", bus_if.dc_n, 12'hEBE);
      check("rst_steps", {bus_if.step_up, bus_if.step_dn, bus_if.step_crs}, 3'b000);
      check("rst_slewing", bus_if.slewing, 1'b0);

      // Fine-pulse table in TRACK, including wrap in both directions.
      for (int i = 0; i < 9; i++) begin
         apply_fine(vecs[i].up, vecs[i].dn);
         check("vec_angle", bus_if.angle, vecs[i].angle);
         check("vec_steps", {bus_if.step_up, bus_if.step_dn}, {vecs[i].su, vecs[i].sd});
         @(negedge clk);
         check("vec_dc_n", bus_if.dc_n, dc_model(vecs[i].angle));
      end

      // Error present for DEBOUNCE-1 synced cycles: no coarse step.
      bus_if.dir = 1'b1;
      flag = 1'b0;
      @(negedge clk);
      bus_if.tlc1 = 1'b1;
      repeat (DEBOUNCE - 1) @(negedge clk);
      bus_if.tlc1 = 1'b0;
      repeat (20) begin
         @(negedge clk);
         flag = flag | bus_if.slewing;
      end
      check("short_err_slewing", flag, 1'b0);
      check("short_err_angle", bus_if.angle, exp_angle);

      // Walk up to 0x0010, then slew up three coarse steps.
      for (int i = 0; i < 16; i++) apply_fine(1'b1, 1'b0);
      check("walk_angle", bus_if.angle, 16'h0010);
      slew_n(3, 1'b1, 1'b0);
      check("slew_up_angle", bus_if.angle, 16'h0610);

      // Error present for exactly DEBOUNCE synced cycles: exactly one step down.
      sb_q.push_back('{angle: exp_angle - 16'h0200, up: 1'b0, crs: 1'b1});
      @(negedge clk);
      bus_if.dir  = 1'b0;
      bus_if.tlc1 = 1'b1;
      repeat (DEBOUNCE) @(negedge clk);
      bus_if.tlc1 = 1'b0;
      repeat (30) @(negedge clk);
      exp_angle = exp_angle - 16'h0200;
      check("exact_debounce_angle", bus_if.angle, 16'h0410);
      check("exact_debounce_sb", sb_q.size(), 0);

      // Reset, walk down to 0xFF00, then adhi forces upward slew across the wrap.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_angle = 16'h0000;
      check("rst2_angle", bus_if.angle, 16'h0000);
      for (int i = 0; i < 256; i++) apply_fine(1'b0, 1'b1);
      check("walk_dn_angle", bus_if.angle, 16'hFF00);
      slew_n(2, 1'b0, 1'b1);
      check("adhi_wrap_angle", bus_if.angle, 16'h0300);
      apply_fine(1'b0, 1'b1);
      check("adhi_track_angle", bus_if.angle, 16'h02FF);
      bus_if.adhi = 1'b0;

      // Reset during SETTLE abandons the slew.
      sb_q.push_back('{angle: exp_angle + 16'h0200, up: 1'b1, crs: 1'b1});
      @(negedge clk);
      bus_if.dir  = 1'b1;
      bus_if.tlc1 = 1'b1;
      flag = 1'b0;
      for (int k = 0; k < 60 && !flag; k++) begin
         @(negedge clk);
         flag = bus_if.step_up;
      end
      check("pre_rst_step_seen", flag, 1'b1);
      repeat (2) @(negedge clk);
      check("pre_rst_slewing", bus_if.slewing, 1'b1);
      rst = 1'b1;
      bus_if.tlc1 = 1'b0;
      @(negedge clk);
      check("settle_rst_angle", bus_if.angle, 16'h0000);
      check("settle_rst_slewing", bus_if.slewing, 1'b0);
      check("settle_rst_outs", {bus_if.dc_n, bus_if.step_up, bus_if.step_dn, bus_if.step_crs},
            {12'hEBE, 3'b000});
      rst = 1'b0;
      exp_angle = 16'h0000;
      sb_q.delete();
      repeat (12) @(negedge clk);
      check("post_rst_idle", {bus_if.angle, bus_if.slewing}, {16'h0000, 1'b0});
      apply_fine(1'b1, 1'b1);
      check("both_fine_angle", bus_if.angle, 16'h0000);
      check("both_fine_steps", {bus_if.step_up, bus_if.step_dn}, 2'b00);

      // Octant boundary at 0x6000 and the 0x7E00 point.
      slew_n(48, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) apply_fine(1'b0, 1'b1);
      @(negedge clk);
      check("dc_n_5ff0", bus_if.dc_n, dc_model(16'h5FF0));
      for (int i = 0; i < 16; i++) apply_fine(1'b1, 1'b0);
      @(negedge clk);
      check("angle_6000", bus_if.angle, 16'h6000);
      check("dc_n_6000", bus_if.dc_n, 12'hEBB);
      slew_n(15, 1'b1, 1'b0);
      check("angle_7e00", bus_if.angle, 16'h7E00);
      check("dc_n_7e00", bus_if.dc_n, 12'h1BB);

      repeat (4) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
